// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared ALU constants, state enum and flag bit indices
//
// Purpose: common definitions for the bit-serial subtract path and the flags register.
//   state_e       : sequencer states of the serial subtractor
//   DEFAULT_WIDTH : default operand/result width
//   FLAG_*        : bit positions of Z, N, C(borrow), V in the flags register
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
//
// Purpose: computes one bit of a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, incoming borrow
//   d         : difference bit
//   bout      : outgoing borrow
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor computing a - b - borrow_in over WIDTH cycles
//
// Purpose: one full-subtractor cell per clock, LSB first, with a registered borrow.
// Ports:
//   clk, rst_n             : clock (rising edge), asynchronous active-low reset
//   start                  : request, sampled only in IDLE
//   a, b, borrow_in        : operands, captured on the accepting edge
//   busy                   : high while bits are being processed
//   done                   : one-cycle pulse after result/flags are committed
//   result, borrow_out     : difference and final borrow, held until next done
//   zero, negative, overflow : status flags for the flags register
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Only WIDTH-1 bits are stored: the final bit comes straight from the cell
    // on the committing edge.
    logic [WIDTH-2:0]   diff_sh_q, diff_sh_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLAG_W-1:0]  flags_q, flags_d;

    logic               cell_d;
    logic               cell_bout;
    logic [WIDTH-1:0]   diff_full;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign diff_full = {cell_d, diff_sh_q};

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        result_d  = result_q;
        flags_d   = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
                diff_sh_d = diff_full[WIDTH-1:1];
                brw_d     = cell_bout;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d        = diff_full;
                    flags_d[FLAG_Z] = (diff_full == '0);
                    flags_d[FLAG_N] = diff_full[WIDTH-1];
                    flags_d[FLAG_C] = cell_bout;
                    // Signed overflow of a - b uses the latched operand signs;
                    // the initial borrow does not enter the definition.
                    flags_d[FLAG_V] = (a_msb_q != b_msb_q) && (diff_full[WIDTH-1] != a_msb_q);
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            brw_q     <= 1'b0;
            cnt_q     <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            brw_q     <= brw_d;
            cnt_q     <= cnt_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = flags_q[FLAG_Z];
    assign negative   = flags_q[FLAG_N];
    assign borrow_out = flags_q[FLAG_C];
    assign overflow   = flags_q[FLAG_V];

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       borrow_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .borrow_out (borrow_out),
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {overflow, borrow_out, negative, zero}.
    function automatic logic [3:0] flags_now();
        return {overflow, borrow_out, negative, zero};
    endfunction

    // Runs one operation from IDLE. After acceptance the operand inputs are
    // scrambled; with hold_start the request stays high with all-ones operands
    // until the done pulse, which must have no effect.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tbin, input logic [7:0] exp_res,
                         input logic [3:0] exp_flags, input bit hold_start);
        int busy_cnt;
        int cycles;
        logic [7:0] res_before;
        bit stable_ok;
        @(negedge clk);
        a = ta; b = tb; borrow_in = tbin; start = 1'b1;
        res_before = result;
        @(negedge clk);
        if (hold_start) begin
            a = 8'hFF; b = 8'hFF; borrow_in = 1'b1;
        end else begin
            start = 1'b0; a = ~ta; b = 8'($urandom); borrow_in = ~tbin;
        end
        busy_cnt  = 0;
        cycles    = 0;
        stable_ok = 1'b1;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (result !== res_before) stable_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        chk({tag, " done_seen"}, {31'd0, done}, 32'd1);
        start = 1'b0;
        chk({tag, " busy_width"}, busy_cnt, 32'd8);
        chk({tag, " result_stable_in_run"}, {31'd0, stable_ok}, 32'd1);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " flags"}, flags_now(), exp_flags);
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, " done_single"}, {31'd0, done}, 32'd0);
        chk({tag, " idle_after_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result_held"}, result, exp_res);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [8:0] wide;
        logic [7:0] mres;
        logic [3:0] mflags;
        int         seen_done;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", flags_now(), 32'd0);
        rst_n = 1'b1;

        // Scenario 1..3: directed vectors, flags {V,C,N,Z}
        do_op("t1_5m3",    8'h05, 8'h03, 1'b0, 8'h02, 4'b0000, 1'b0);
        do_op("t2_3m5",    8'h03, 8'h05, 1'b0, 8'hFE, 4'b0110, 1'b0);
        do_op("t2_80m1",   8'h80, 8'h01, 1'b0, 8'h7F, 4'b1000, 1'b0);
        do_op("t3_eq",     8'h42, 8'h42, 1'b0, 8'h00, 4'b0001, 1'b0);
        do_op("t3_bin",    8'h10, 8'h0F, 1'b1, 8'h00, 4'b0001, 1'b0);
        do_op("t3_wrap",   8'h00, 8'h00, 1'b1, 8'hFF, 4'b0110, 1'b0);

        // Scenario 4: start held with all-ones operands during RUN is ignored
        do_op("t4_hold",   8'h20, 8'h01, 1'b0, 8'h1F, 4'b0000, 1'b1);
        do_op("t4_next",   8'h7F, 8'hFF, 1'b0, 8'h80, 4'b1110, 1'b0);

        // Scenario 5: reset in the middle of RUN
        @(negedge clk);
        a = 8'h55; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 busy_reset", {31'd0, busy}, 32'd0);
        chk("t5 done_reset", {31'd0, done}, 32'd0);
        chk("t5 result_reset", result, 32'd0);
        chk("t5 flags_reset", flags_now(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("t5 no_done_after_abort", seen_done, 32'd0);
        do_op("t5_after",  8'h09, 8'h04, 1'b0, 8'h05, 4'b0000, 1'b0);

        // Scenario 6: randomized regression against arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            wide = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            mres = wide[7:0];
            mflags = {(ra[7] != rb[7]) && (mres[7] != ra[7]), wide[8], mres[7], mres == 8'h00};
            do_op("t6_rand", ra, rb, rbin, mres, mflags, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
